// File: rtl/sa_out_collector.sv
// sa_out_collector
// ----------------
// Output collector for the systolic-array row outputs. Each lane's
// {valid, data} pair is registered. The one-cycle-per-row skew is then removed
// so that every lane of a wavefront arrives in the same cycle. Each aligned
// wavefront that has at least one valid lane is pushed into a DEPTH-entry FIFO.
// The FIFO drains over a valid/ready handshake.
//
// Optional feature (macro SA_OUT_DESKEW_EN):
//   defined   : lane i passes through ROW-1-i extra registers after the input
//               stage. A wavefront whose lane 0 arrives in cycle t is written at
//               the end of cycle t+ROW.
//   undefined : no delay lines. The push is decided straight from the input
//               register stage, which gives two cycles of latency for any ROW.
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_rst        asynchronous active-high reset
//   i_data       ROW lanes of W_DATA bits, lane 0 in the MSBs
//   i_data_valid per-lane valid, bit i qualifies lane i
//   o_data       FIFO head, lane i = {valid_i, data_i}, lane 0 in the MSBs;
//                all zeros while o_valid is 0
//   o_valid      FIFO non-empty
//   i_ready      consumer takes the head this cycle
//   o_count      number of entries held, 0..DEPTH
//   o_overflow   sticky flag, set when a wavefront is dropped on a full FIFO
module sa_out_collector #(
    parameter int ROW    = 8,
    parameter int W_DATA = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [ROW*W_DATA-1:0]        i_data,
    input  logic [ROW-1:0]               i_data_valid,
    output logic [(W_DATA+1)*ROW-1:0]    o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);
    localparam int LW = W_DATA + 1;       // lane width once the valid bit is attached
    localparam int FW = LW * ROW;         // one FIFO entry
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FW-1:0]  wf_flat;              // aligned wavefront in output layout
    logic [ROW-1:0] aligned_valid;

    genvar gi;
    generate
        for (gi = 0; gi < ROW; gi++) begin : g_lane
            logic [LW-1:0] in_d;
            logic [LW-1:0] in_q;
            logic [LW-1:0] lane_out;

            always_comb begin
                in_d = {i_data_valid[gi], i_data[W_DATA*(ROW-gi)-1 -: W_DATA]};
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) in_q <= '0;
                else       in_q <= in_d;
            end

`ifdef SA_OUT_DESKEW_EN
            // Earlier lanes arrive earlier, so they are held longer. Lane ROW-1
            // is the last to arrive and bypasses the delay line.
            localparam int NSTG = ROW - 1 - gi;
            if (NSTG == 0) begin : g_nodly
                assign lane_out = in_q;
            end else begin : g_dly
                logic [LW-1:0] dly_d [NSTG];
                logic [LW-1:0] dly_q [NSTG];

                always_comb begin
                    dly_d[0] = in_q;
                    for (int s = 1; s < NSTG; s++) dly_d[s] = dly_q[s-1];
                end

                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        for (int s = 0; s < NSTG; s++) dly_q[s] <= '0;
                    end else begin
                        dly_q <= dly_d;
                    end
                end

                assign lane_out = dly_q[NSTG-1];
            end
`else
            assign lane_out = in_q;
`endif

            assign aligned_valid[gi]             = lane_out[LW-1];
            assign wf_flat[LW*(ROW-gi)-1 -: LW]  = lane_out;
        end
    endgenerate

    // FIFO state
    logic [FW-1:0] mem_d [DEPTH];
    logic [FW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          ovf_d, ovf_q;

    logic push, pop, full, push_ok;

    assign push    = |aligned_valid;
    assign o_valid = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = o_valid & i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    // The write then lands in the slot being vacated (wr_ptr == rd_ptr).
    assign push_ok = push & (~full | pop);

    always_comb begin
        for (int d = 0; d < DEPTH; d++) mem_d[d] = mem_q[d];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = wf_flat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push & ~push_ok) ovf_d = 1'b1;
    end

    // Storage only; entries past the count are never shown (o_data is masked).
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_sa_out_collector.sv
// Testbench for sa_out_collector (ROW=4, W_DATA=8, DEPTH=4).
// Stimulus is written as logical wavefronts. When SA_OUT_DESKEW_EN is defined,
// the bench presents lane i of each wavefront i cycles after lane 0. Expected
// heads are queued when a wavefront is issued. A negedge monitor pops the queue
// and compares on every handshake.
module tb_sa_out_collector;
    localparam int ROW   = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = W + 1;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef SA_OUT_DESKEW_EN
    localparam int LAT = ROW + 1;   // issue cycle to first o_valid cycle
`else
    localparam int LAT = 2;
`endif

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic [ROW*W-1:0]     i_data;
    logic [ROW-1:0]       i_data_valid;
    logic [LW*ROW-1:0]    o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [CW-1:0]        o_count;
    logic                 o_overflow;

    sa_out_collector #(.ROW(ROW), .W_DATA(W), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [LW*ROW-1:0] exp_q [$];
    logic [ROW*W-1:0]  hist_d [ROW];
    logic [ROW-1:0]    hist_v [ROW];
    logic [ROW*W-1:0]  wave_tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %0h", name, act);
        end
    endtask

    function automatic logic [LW*ROW-1:0] pack(input logic [ROW*W-1:0] d, input logic [ROW-1:0] v);
        logic [LW*ROW-1:0] r;
        r = '0;
        for (int i = 0; i < ROW; i++) r[LW*(ROW-i)-1 -: LW] = {v[i], d[W*(ROW-i)-1 -: W]};
        return r;
    endfunction

    // Monitor: compare the head on every handshake and insist on a zero head when idle.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", o_data);
                end else begin
                    chk("head", 64'(o_data), 64'(exp_q.pop_front()));
                end
            end else if (!o_valid && o_data != '0) begin
                tests++;
                fails++;
                $display("FAIL idle_data_zero: got %0h expected 0", o_data);
            end
        end
    end

    // One cycle: shift the wavefront history, drive the lanes, then advance.
    task automatic step(input logic [ROW*W-1:0] d, input logic [ROW-1:0] v, input logic rdy);
        for (int k = ROW - 1; k > 0; k--) begin
            hist_d[k] = hist_d[k-1];
            hist_v[k] = hist_v[k-1];
        end
        hist_d[0] = d;
        hist_v[0] = v;
        for (int i = 0; i < ROW; i++) begin
`ifdef SA_OUT_DESKEW_EN
            i_data[W*(ROW-i)-1 -: W] = hist_d[i][W*(ROW-i)-1 -: W];
            i_data_valid[i]          = hist_v[i][i];
`else
            i_data[W*(ROW-i)-1 -: W] = hist_d[0][W*(ROW-i)-1 -: W];
            i_data_valid[i]          = hist_v[0][i];
`endif
        end
        i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step('0, '0, rdy);
    endtask

    task automatic issue(input logic [ROW*W-1:0] d, input logic [ROW-1:0] v, input logic rdy,
                         input logic keep, input logic [LW*ROW-1:0] exp);
        if (keep) exp_q.push_back(exp);
        step(d, v, rdy);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < ROW; k++) begin
            hist_d[k] = '0;
            hist_v[k] = '0;
        end
        i_data       = '0;
        i_data_valid = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_stim();
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Single wavefront with i_ready held high: o_valid must be high in exactly one cycle.
    task automatic run_single(input string name, input logic [ROW*W-1:0] d, input logic [LW*ROW-1:0] exp);
        issue(d, 4'hF, 1'b1, 1'b1, exp);
        for (int j = 1; j <= LAT + 1; j++) begin
            chk($sformatf("%s_valid_c%0d", name, j), 64'(o_valid), 64'(j == LAT));
            step('0, '0, 1'b1);
        end
    endtask

    initial begin
        wave_tbl[0] = 32'h10111213; wave_tbl[1] = 32'h20212223; wave_tbl[2] = 32'h30313233;
        wave_tbl[3] = 32'h40414243; wave_tbl[4] = 32'h50515253; wave_tbl[5] = 32'h60616263;
        i_rst   = 1'b1;
        i_ready = 1'b0;
        clear_stim();
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_ovf",   64'(o_overflow), 64'd0);
        chk("rst_data",  64'(o_data), 64'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Skewed single wavefront
        run_single("single", 32'h11223344, {9'h111, 9'h122, 9'h133, 9'h144});

        // Partial wavefront: only lane 2 valid; invalid lanes keep their data
        issue(32'h5A00A53C, 4'b0100, 1'b0, 1'b1, {9'h05A, 9'h000, 9'h1A5, 9'h03C});
        idle(LAT, 1'b0);
        chk("partial_count", 64'(o_count), 64'd1);
        chk("partial_valid", 64'(o_valid), 64'd1);
        idle(1, 1'b1);
        chk("partial_drained", 64'(o_count), 64'd0);

        // Backpressure and overflow: six wavefronts, the last two dropped
        for (int k = 0; k < 6; k++) issue(wave_tbl[k], 4'hF, 1'b0, k < 4, pack(wave_tbl[k], 4'hF));
        idle(LAT, 1'b0);
        chk("bp_count", 64'(o_count), 64'd4);
        chk("bp_ovf",   64'(o_overflow), 64'd1);
        idle(6, 1'b1);
        chk("bp_drained", 64'(o_count), 64'd0);
        chk("bp_ovf_sticky", 64'(o_overflow), 64'd1);
        do_reset();
        chk("ovf_cleared", 64'(o_overflow), 64'd0);

        // Full with a simultaneous push and pop
        for (int k = 0; k < 4; k++) issue(32'hA0A1A2A3 + 32'h01010101 * k, 4'hF, 1'b0, 1'b1,
                                          pack(32'hA0A1A2A3 + 32'h01010101 * k, 4'hF));
        idle(LAT, 1'b0);
        chk("full_count", 64'(o_count), 64'd4);
        issue(32'hE0E1E2E3, 4'hF, 1'b0, 1'b1, {9'h1E0, 9'h1E1, 9'h1E2, 9'h1E3});
        idle(LAT - 2, 1'b0);
        idle(1, 1'b1);          // push of E and pop of the first entry in the same cycle
        chk("full_pushpop_count", 64'(o_count), 64'd4);
        chk("full_pushpop_ovf",   64'(o_overflow), 64'd0);
        idle(6, 1'b1);
        chk("full_drained", 64'(o_count), 64'd0);

        // Reset mid-operation
        issue(32'hC1C2C3C4, 4'hF, 1'b0, 1'b1, pack(32'hC1C2C3C4, 4'hF));
        issue(32'hD1D2D3D4, 4'hF, 1'b0, 1'b1, pack(32'hD1D2D3D4, 4'hF));
        idle(LAT, 1'b0);
        chk("mid_count", 64'(o_count), 64'd2);
        issue(32'hF1F2F3F4, 4'hF, 1'b0, 1'b0, '0);
        idle(1, 1'b0);
        i_rst = 1'b1;
        clear_stim();
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_count", 64'(o_count), 64'd0);
        chk("mid_rst_data",  64'(o_data), 64'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        idle(LAT + 4, 1'b1);
        chk("post_rst_count", 64'(o_count), 64'd0);
        chk("post_rst_valid", 64'(o_valid), 64'd0);

`ifndef SA_OUT_DESKEW_EN
        // Aligned lanes without a deskew stage
        run_single("aligned", 32'h01020304, {9'h101, 9'h102, 9'h103, 9'h104});
`endif

        idle(2, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sa_out_collector.md
# sa_out_collector

Output collector for the systolic-array row outputs. Captures ROW lanes of W_DATA-bit results with per-lane valids, removes the one-cycle-per-row systolic skew, appends each lane's valid bit to its data, and buffers the aligned wavefronts in a DEPTH-entry FIFO. The FIFO drains to the downstream consumer over a valid/ready handshake. It sits between the array's last column and the result writeback path.

## Interface
- ROW, 8, number of array rows (lanes), ≥1
- W_DATA, 8, data bits per lane; output lane width is W_DATA+1
- DEPTH, 4, FIFO entries, power of two, ≥2
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset: one clock; reset is asynchronous and active-high
- i_data  input  ROW*W_DATA  lane i at i_data[W_DATA*(ROW-i)-1 -: W_DATA] (lane 0 in MSBs)
- i_data_valid  input  ROW  bit i qualifies lane i
- o_data  output  (W_DATA+1)*ROW  FIFO head; lane i at o_data[(W_DATA+1)*(ROW-i)-1 -: W_DATA+1] = {valid_i, data_i}
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer accepts head this cycle
- o_count  output  $clog2(DEPTH+1)  entries held
- o_overflow  output  1  sticky: a wavefront was dropped

## Operation
- Input stage: every cycle, all lanes {i_data_valid[i], data_i} are registered unconditionally.
- Deskew: lane i's registered value passes through ROW-1-i further registers; lane ROW-1 has no extra delay. A wavefront is lane 0 presented in cycle t, lane i in cycle t+i; all lanes emerge together.
- Push: an aligned wavefront is written when any aligned lane valid is 1. Lanes with valid 0 are written as {0, data unchanged}. An all-invalid wavefront is never written.
- Pop: when o_valid && i_ready, head is removed.
- Accept rule: push is accepted if count < DEPTH, or if count == DEPTH and a pop happens in the same cycle.
- Drop rule: a push at count == DEPTH with no pop is dropped. The FIFO is left unchanged and o_overflow sets to 1.
- o_overflow clears only on reset.
- Simultaneous push and pop at any count: count unchanged, order preserved.
- Pop with i_ready while empty has no effect.
- o_data is all zeros whenever o_valid is 0.
- Pointers wrap modulo DEPTH. o_count is the exact entry count 0..DEPTH.

## Timing
- Reset (async assert, any cycle) clears all input/deskew registers, pointers and count; in-flight wavefronts are lost.
- Outputs while reset is asserted and after it: o_valid=0, o_data=0, o_count=0, o_overflow=0.
- Deskew enabled: wavefront with lane 0 in cycle t is written at the end of cycle t+ROW. o_valid=1 from cycle t+ROW+1 if the FIFO was empty.
- Deskew disabled: written at end of t+1; o_valid from t+2.
- Throughput: one wavefront per cycle in, one per cycle out.
- Pop effect: after a pop at the end of cycle c, the next head shows in c+1. A push and a pop in the same cycle both complete.

## Configuration
- SA_OUT_DESKEW_EN defined: per-lane delay lines as above (ROW-1-i stages for lane i).
- SA_OUT_DESKEW_EN undefined: no delay lines. All lanes of a wavefront are expected in the same cycle. Push is decided directly from the input register stage, and total latency is 2 cycles for every ROW.

## Test plan
All scenarios use ROW=4, W_DATA=8, DEPTH=4, with SA_OUT_DESKEW_EN defined unless stated.
- Skewed single wavefront: lanes 0..3 = 0x11,0x22,0x33,0x44 with valid in cycles 0..3, i_ready=1 -> o_valid=1 in cycle 5 only, o_data=0x1_11_1_22_1_33_1_44 as {v,d} per lane (MSB first).
- Partial wavefront: only lane 2 valid (0xA5) at cycle 2 -> one entry, lanes 0,1,3 valid bit 0, lane 2 = {1,0xA5}, o_count=1.
- Backpressure and overflow: i_ready=0, six back-to-back wavefronts -> o_count reaches 4. Wavefronts 5 and 6 are dropped, o_overflow=1 and stays 1. After i_ready=1 the first four drain in order.
- Full with simultaneous pop: count=4, push and pop in the same cycle -> count stays 4, new entry kept at tail, o_overflow stays 0.
- Reset mid-operation: assert i_rst with 2 entries queued and 1 wavefront in the deskew lines -> o_valid=0, o_count=0, o_data=0 immediately. No output appears after release.
- Macro off: aligned lanes 0x01..0x04 all valid in cycle 0 -> o_valid=1 in cycle 2 with matching data.
